// File: rtl/spi_program_fetch_pkg.sv
// Shared types and constants for the SPI program fetch front-end.
package spi_program_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int         DEFAULT_INPUT_DATA_WIDTH = 4;
  localparam int         WORD_WIDTH               = 4 * DEFAULT_INPUT_DATA_WIDTH;
  localparam logic [7:0] NOP_OPCODE               = 8'h00;

  // SPI word width for an arbitrary nibble width: {opcode, operand}.
  function automatic int word_width(input int input_data_width);
    return 4 * input_data_width;
  endfunction

endpackage

// File: rtl/spi_program_fetch_word_receiver.sv
// SPI mode-0 write-only word receiver: synchronises sclk/cs_n/mosi into clk,
// detects edges and assembles MSB-first words.
module spi_word_receiver
  import spi_program_fetch_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_cs_rise,
  output logic              o_cs_fall
);

  localparam int CW = $clog2(WORD_W);

  // [0] first sync flop, [1] synchronised value, [2] previous synchronised value
  logic [2:0]        r_sclk_s;
  logic [2:0]        r_cs_s;
  logic [1:0]        r_mosi_s;
  logic [WORD_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;

  logic              w_sclk_rise;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic [WORD_W-1:0] w_shift_next;

  assign w_sclk_rise  = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_cs_rise    = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall    = ~r_cs_s[1] & r_cs_s[2];
  assign w_shift_next = {r_shift[WORD_W-2:0], r_mosi_s[1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_s     <= 3'b000;
      r_cs_s       <= 3'b111;
      r_mosi_s     <= 2'b00;
      r_shift      <= '0;
      r_cnt        <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_cs_rise    <= 1'b0;
      o_cs_fall    <= 1'b0;
    end else begin
      r_sclk_s     <= {r_sclk_s[1:0], i_sclk};
      r_cs_s       <= {r_cs_s[1:0], i_cs_n};
      r_mosi_s     <= {r_mosi_s[0], i_mosi};
      o_cs_rise    <= w_cs_rise;
      o_cs_fall    <= w_cs_fall;
      o_word_valid <= 1'b0;
      // Either chip-select edge throws away any partially received word.
      if (w_cs_rise || w_cs_fall) begin
        r_cnt <= '0;
      end else if (w_sclk_rise && !r_cs_s[1]) begin
        r_shift <= w_shift_next;
        if (r_cnt == CW'(WORD_W - 1)) begin
          r_cnt        <= '0;
          o_word_valid <= 1'b1;
          o_word       <= w_shift_next;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_program_fetch.sv
// SPI-loaded program buffer that sequences instructions to the execution unit.
// Define SPI_PROGRAM_FETCH_LOOP_EN to re-run the program forever after each start pulse.
//
// state | meaning
// IDLE  | waiting for a cs_n fall
// LOAD  | receiving words into the program buffer
// RUN   | presenting buf[pc] on opcode/operand, one per clk
// DONE  | NOP cycle, then one-cycle start pulse
module spi_program_fetch
  import spi_program_fetch_pkg::*;
#(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic [2*INPUT_DATA_WIDTH-1:0] opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0] operand,
  output logic                          start,
  output logic                          busy,
  output logic                          overflow,
  output logic [ROM_ADDRESS_WIDTH-1:0]  pc
);

  localparam int AW    = ROM_ADDRESS_WIDTH;
  localparam int HW    = 2 * INPUT_DATA_WIDTH;
  localparam int WW    = word_width(INPUT_DATA_WIDTH);
  localparam int DEPTH = 2 ** AW;

  state_t        r_state;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_len;
  logic          r_nop_done;
  logic [WW-1:0] r_buf [DEPTH];

  logic          w_word_valid;
  logic [WW-1:0] w_word;
  logic          w_cs_rise;
  logic          w_cs_fall;
  logic          w_full;
  logic          w_buf_we;
  logic          w_last;
  logic [WW-1:0] w_rd;

  spi_word_receiver #(
    .WORD_W (WW)
  ) u_rx (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_cs_rise    (w_cs_rise),
    .o_cs_fall    (w_cs_fall)
  );

  assign w_full   = (r_wptr == (AW+1)'(DEPTH));
  assign w_buf_we = (r_state == LOAD) && w_word_valid && !w_cs_rise && !w_cs_fall && !w_full;
  assign w_last   = ({1'b0, pc} == (r_len - (AW+1)'(1)));
  assign w_rd     = r_buf[pc];

  // Program storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wptr[AW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_len      <= '0;
      r_nop_done <= 1'b0;
      opcode     <= HW'(NOP_OPCODE);
      operand    <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      pc         <= '0;
    end else begin
      start <= 1'b0;
      if (w_cs_fall) begin
        r_state    <= LOAD;
        r_wptr     <= '0;
        r_nop_done <= 1'b0;
        overflow   <= 1'b0;
        opcode     <= HW'(NOP_OPCODE);
        operand    <= '0;
        pc         <= '0;
        busy       <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            busy <= 1'b0;
          end
          LOAD: begin
            if (w_cs_rise) begin
              r_len <= r_wptr;
              pc    <= '0;
              if (r_wptr == '0) begin
                r_state <= IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= RUN;
                busy    <= 1'b1;
              end
            end else if (w_word_valid) begin
              if (w_full) begin
                overflow <= 1'b1;
              end else begin
                r_wptr <= r_wptr + 1'b1;
              end
            end
          end
          RUN: begin
            opcode  <= w_rd[WW-1:HW];
            operand <= w_rd[HW-1:0];
            if (w_last) begin
              r_state <= DONE;
              busy    <= 1'b0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
          DONE: begin
            opcode  <= HW'(NOP_OPCODE);
            operand <= '0;
            // First DONE cycle lets the last instruction retire; second fires start.
            if (!r_nop_done) begin
              r_nop_done <= 1'b1;
            end else begin
              r_nop_done <= 1'b0;
              start      <= 1'b1;
`ifdef SPI_PROGRAM_FETCH_LOOP_EN
              r_state <= RUN;
              busy    <= 1'b1;
              pc      <= '0;
`else
              r_state <= IDLE;
`endif
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_program_fetch.md
Name: spi_program_fetch

Overview:
- Front-end stage directly upstream of the execution unit.
- Receives a program over a write-only SPI slave link (mode 0, MSB first, 16-bit words {opcode, operand}) and stores it in an internal program buffer.
- Then sequences the buffer, one instruction per clk, onto the execution unit's opcode/operand inputs.
- After the last instruction it pulses start so the execution unit latches its output register.

Parameters:
- ROM_ADDRESS_WIDTH, 5, buffer address width; depth = 2**ROM_ADDRESS_WIDTH words.
- INPUT_DATA_WIDTH, 4, nibble width; opcode and operand are each 2*INPUT_DATA_WIDTH bits; SPI word = 4*INPUT_DATA_WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- opcode  out  2*INPUT_DATA_WIDTH  instruction to execution unit.
- operand  out  2*INPUT_DATA_WIDTH  operand to execution unit.
- start  out  1  one-cycle pulse; execution unit captures its output register.
- busy  out  1  high in LOAD or RUN.
- overflow  out  1  sticky: a word was dropped because the buffer was full.
- pc  out  ROM_ADDRESS_WIDTH  index of the instruction currently presented.

Behaviour:
- Reset (reset low, async) values:
  - state=IDLE; opcode=0, operand=0 (8'h00 is the NOP encoding); start=0, busy=0, overflow=0, pc=0.
  - write pointer=0, length=0, shift count=0. Buffer contents are not reset.
- Sampling and synchronisation:
  - sclk, cs_n and mosi each pass through a 2-FF synchroniser.
  - An sclk rising edge is detected in the clk domain; mosi is sampled on that edge.
  - clk >= 4x sclk is required.
  - Input-to-internal-event latency is 3 clk.
- cs_n falling edge, any state: enter LOAD.
  - Write pointer=0, bit count=0, overflow=0.
  - An active RUN is aborted; opcode/operand go to 0 the next cycle. No start pulse is issued.
- LOAD:
  - Each sampled bit shifts in MSB first.
  - On the 16th bit, the word is written to buf[wptr], wptr increments and the bit count clears.
  - Buffer full (wptr == depth): the word is dropped and overflow is set. wptr does not wrap.
- cs_n rising edge in LOAD:
  - Partial words are discarded.
  - length=wptr.
  - length==0 -> IDLE, no start.
  - Otherwise -> RUN with pc=0.
- RUN:
  - Each clk, opcode=buf[pc][15:8] and operand=buf[pc][7:0] are registered outputs, valid the cycle after pc updates.
  - pc increments every cycle until pc==length-1.
  - The cycle after the last instruction is presented: go to DONE, drive opcode/operand=0.
- DONE: one NOP cycle, so the last register writes land. Then start=1 for exactly one cycle and go to IDLE.
  - Total from RUN entry to start pulse: length+2 clk.
- Boundary conditions:
  - SPI edges during RUN/DONE other than a cs_n fall are ignored.
  - Reset mid-LOAD or mid-RUN returns all outputs to reset values immediately.

Optional Feature:
- Macro: SPI_PROGRAM_FETCH_LOOP_EN.
- Defined: after the start pulse the block returns to RUN with pc=0, not IDLE. The program re-executes forever, with a start pulse every length+2 clk, until a cs_n fall or reset.
- Undefined: single-shot behaviour as above.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - WORD_WIDTH = 4*INPUT_DATA_WIDTH;
  - NOP_OPCODE = 8'h00.
- Sub-module spi_word_receiver: synchronisers, edge detect, shift register and bit counter.
  - Outputs: word_valid pulse, word data, cs_rise, cs_fall.
- Parent holds: FSM, buffer, pointers, pc, outputs.

Test Plan:
1. Reset low mid-frame -> all outputs 0, state IDLE; release and load nothing -> no start.
2. Load 3 words 0x1234, 0x5678, 0x9ABC, then cs_n high -> busy; opcode/operand present 12/34, 56/78, 9A/BC on consecutive clks; then 00/00; start high exactly one clk, length+2 clk after RUN entry.
3. Load 33 words at default depth 32 -> overflow=1, length=32, 32 instructions issued; the 33rd word is never seen.
4. Send 20 bits then raise cs_n -> only 1 word stored; the 4 trailing bits are discarded.
5. cs_n fall during RUN at pc=1 -> opcode=0 the next cycle, no start, new load accepted and run correctly.
6. With SPI_PROGRAM_FETCH_LOOP_EN, load 2 words -> start pulses every 4 clk, pc cycles 0,1,0,1.
